// File: rtl/sram_arb_pkg.sv
// Shared constants and request type for the two-port SRAM arbiter.
// ADDR_W/DATA_W/STRB_W size the SRAM side; RSP_DEPTH sizes each per-port
// response FIFO and therefore the number of reads a port may have outstanding.
package sram_arb_pkg;

    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 128;
    localparam int STRB_W     = DATA_W / 8;
    localparam int RSP_DEPTH  = 2;
    localparam int SRAM_WORDS = 1 << ADDR_W;
    localparam int CNT_W      = $clog2(RSP_DEPTH + 1);

    // Identifies a requester; also the round-robin pointer value.
    typedef enum logic {
        PORT_0 = 1'b0,
        PORT_1 = 1'b1
    } port_e;

    // One SRAM access as presented by a requester.
    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } sram_req_t;

endpackage

// File: rtl/sram_1024x128b.sv
// Single-port synchronous SRAM, 1024 words x 128 bits, byte-strobed writes.
// Ports: clk; cen (access enable); wen (1 = write); addr; wdata; wstrb
// (byte enables); rdata (registered read data, valid the cycle after a
// read access and held until the next read). Contents are never reset.
module sram_1024x128b
    import sram_arb_pkg::*;
(
    input  logic              clk,
    input  logic              cen,
    input  logic              wen,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [SRAM_WORDS];
    logic [DATA_W-1:0] rdata_q;

    // Writes merge only the strobed bytes; reads capture the whole word.
    always_ff @(posedge clk) begin
        if (cen) begin
            if (wen) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (wstrb[b]) begin
                        mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/sram_rsp_fifo.sv
// Small synchronous FIFO holding read responses for one port.
// Ports: clk, rst (sync, active-high); push/push_data (write side, caller
// guarantees space); pop_ready (consumer ready); rsp_valid/rsp_data (head
// entry, straight from registers); count (current occupancy).
module sram_rsp_fifo
    import sram_arb_pkg::*;
#(
    parameter int DEPTH = RSP_DEPTH,
    parameter int WIDTH = DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop_ready,
    output logic                       rsp_valid,
    output logic [WIDTH-1:0]           rsp_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Push and pop are independent; a simultaneous pair leaves count unchanged.
    always_comb begin
        pop      = (count_q != '0) && pop_ready;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Storage is cleared on reset so the response data output reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rsp_valid = (count_q != '0);
    assign rsp_data  = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/sram_arb_ctrl.sv
// Two-port round-robin arbiter and sequencer in front of one SRAM.
// Ports: clk, rst (sync, active-high); per port X in {0,1}:
//   pX_req_valid/ready/write/addr/wdata/wstrb  request handshake
//   pX_rsp_valid/ready/rdata                   read response handshake
// One access per cycle reaches the SRAM. A port may only be granted a read
// while its credit (FIFO occupancy + its own read in flight) is below
// RSP_DEPTH, so the response FIFO can never overflow. Writes are posted.
module sram_arb_ctrl
    import sram_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_write,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [DATA_W-1:0] p0_req_wdata,
    input  logic [STRB_W-1:0] p0_req_wstrb,
    output logic              p0_rsp_valid,
    input  logic              p0_rsp_ready,
    output logic [DATA_W-1:0] p0_rsp_rdata,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_write,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_wdata,
    input  logic [STRB_W-1:0] p1_req_wstrb,
    output logic              p1_rsp_valid,
    input  logic              p1_rsp_ready,
    output logic [DATA_W-1:0] p1_rsp_rdata
);

    localparam int CRD_W = CNT_W + 1;

    sram_req_t         p0_req, p1_req, sel_req;
    logic [CNT_W-1:0]  count0, count1;
    logic [CRD_W-1:0]  credit0, credit1;
    logic              elig0, elig1, gnt0, gnt1;
    logic              sram_cen, sram_wen;
    logic [DATA_W-1:0] sram_rdata;
    port_e             last_grant_q, last_grant_d;
    port_e             inflight_port_q, inflight_port_d;
    logic              inflight_q, inflight_d;

    assign p0_req = '{write: p0_req_write, addr: p0_req_addr,
                      wdata: p0_req_wdata, wstrb: p0_req_wstrb};
    assign p1_req = '{write: p1_req_write, addr: p1_req_addr,
                      wdata: p1_req_wdata, wstrb: p1_req_wstrb};

    // Credit uses this cycle's occupancy; a pop in the same cycle frees
    // nothing until the count register updates.
    assign credit0 = {1'b0, count0} + CRD_W'(inflight_q && (inflight_port_q == PORT_0));
    assign credit1 = {1'b0, count1} + CRD_W'(inflight_q && (inflight_port_q == PORT_1));
    assign elig0   = p0_req_valid && (p0_req_write || (credit0 < CRD_W'(RSP_DEPTH)));
    assign elig1   = p1_req_valid && (p1_req_write || (credit1 < CRD_W'(RSP_DEPTH)));

    // On a tie the port that was not granted last wins; grants are held off
    // during reset so ready reads zero.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (elig0 && elig1) begin
                if (last_grant_q == PORT_1) gnt0 = 1'b1;
                else                        gnt1 = 1'b1;
            end else begin
                gnt0 = elig0;
                gnt1 = elig1;
            end
        end
        last_grant_d = last_grant_q;
        if (gnt0)      last_grant_d = PORT_0;
        else if (gnt1) last_grant_d = PORT_1;
        inflight_d      = (gnt0 && !p0_req_write) || (gnt1 && !p1_req_write);
        inflight_port_d = gnt1 ? PORT_1 : PORT_0;
        sel_req         = gnt1 ? p1_req : p0_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q    <= PORT_1;
            inflight_q      <= 1'b0;
            inflight_port_q <= PORT_0;
        end else begin
            last_grant_q    <= last_grant_d;
            inflight_q      <= inflight_d;
            inflight_port_q <= inflight_port_d;
        end
    end

    assign p0_req_ready = gnt0;
    assign p1_req_ready = gnt1;
    assign sram_cen     = gnt0 || gnt1;
    assign sram_wen     = sram_cen && sel_req.write;

    sram_1024x128b u_sram (
        .clk   (clk),
        .cen   (sram_cen),
        .wen   (sram_wen),
        .addr  (sel_req.addr),
        .wdata (sel_req.wdata),
        .wstrb (sel_req.wstrb),
        .rdata (sram_rdata)
    );

    // The word read last cycle lands in the FIFO of the port that asked.
    sram_rsp_fifo #(.DEPTH(RSP_DEPTH), .WIDTH(DATA_W)) u_fifo0 (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q && (inflight_port_q == PORT_0)),
        .push_data (sram_rdata),
        .pop_ready (p0_rsp_ready),
        .rsp_valid (p0_rsp_valid),
        .rsp_data  (p0_rsp_rdata),
        .count     (count0)
    );

    sram_rsp_fifo #(.DEPTH(RSP_DEPTH), .WIDTH(DATA_W)) u_fifo1 (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q && (inflight_port_q == PORT_1)),
        .push_data (sram_rdata),
        .pop_ready (p1_rsp_ready),
        .rsp_valid (p1_rsp_valid),
        .rsp_data  (p1_rsp_rdata),
        .count     (count1)
    );

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// Self-checking bench for sram_arb_ctrl. A transaction-level model (word
// array, per-port queues of outstanding reads with their due cycle) predicts
// grants, response valid and response data each cycle.
module tb_sram_arb_ctrl;
    import sram_arb_pkg::*;

    localparam logic [DATA_W-1:0] WORD_A = 128'h0123456789ABCDEF0123456789ABCDEF;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid [2];
    logic              req_ready [2];
    logic              req_write [2];
    logic [ADDR_W-1:0] req_addr  [2];
    logic [DATA_W-1:0] req_wdata [2];
    logic [STRB_W-1:0] req_wstrb [2];
    logic              rsp_valid [2];
    logic              rsp_ready [2];
    logic [DATA_W-1:0] rsp_rdata [2];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                avail;
    } rsp_t;

    logic [DATA_W-1:0] mem_model [SRAM_WORDS];
    rsp_t              rq0 [$];
    rsp_t              rq1 [$];
    int                last_g = 1;

    logic              exp_rdy  [2];
    logic              obs_rdy  [2];
    logic              exp_vld  [2];
    logic              obs_vld  [2];
    logic [DATA_W-1:0] exp_data [2];
    logic [DATA_W-1:0] obs_data [2];

    always #5 clk = ~clk;

    sram_arb_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .p0_req_valid (req_valid[0]),
        .p0_req_ready (req_ready[0]),
        .p0_req_write (req_write[0]),
        .p0_req_addr  (req_addr[0]),
        .p0_req_wdata (req_wdata[0]),
        .p0_req_wstrb (req_wstrb[0]),
        .p0_rsp_valid (rsp_valid[0]),
        .p0_rsp_ready (rsp_ready[0]),
        .p0_rsp_rdata (rsp_rdata[0]),
        .p1_req_valid (req_valid[1]),
        .p1_req_ready (req_ready[1]),
        .p1_req_write (req_write[1]),
        .p1_req_addr  (req_addr[1]),
        .p1_req_wdata (req_wdata[1]),
        .p1_req_wstrb (req_wstrb[1]),
        .p1_rsp_valid (rsp_valid[1]),
        .p1_rsp_ready (rsp_ready[1]),
        .p1_rsp_rdata (rsp_rdata[1])
    );

    task automatic set_req(input int p, input logic v, input logic w,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input logic [STRB_W-1:0] s);
        req_valid[p] = v;
        req_write[p] = w;
        req_addr[p]  = a;
        req_wdata[p] = d;
        req_wstrb[p] = s;
    endtask

    function automatic logic [DATA_W-1:0] bp_val(input int k);
        return {4{32'hB0B0_0000 + 32'(k)}};
    endfunction

    // Samples DUT and model at the falling edge, then advances the model
    // across the rising edge using the rules for grant, credit and latency.
    task automatic tick();
        logic elig [2];
        int   g;
        rsp_t ent;
        @(negedge clk);
        elig[0] = req_valid[0] && (req_write[0] || rq0.size() < RSP_DEPTH);
        elig[1] = req_valid[1] && (req_write[1] || rq1.size() < RSP_DEPTH);
        g = -1;
        if (!rst) begin
            if (elig[0] && elig[1]) g = (last_g == 1) ? 0 : 1;
            else if (elig[0])       g = 0;
            else if (elig[1])       g = 1;
        end
        exp_rdy[0]  = (g == 0);
        exp_rdy[1]  = (g == 1);
        exp_vld[0]  = (rq0.size() > 0) && (rq0[0].avail <= cyc);
        exp_vld[1]  = (rq1.size() > 0) && (rq1[0].avail <= cyc);
        exp_data[0] = exp_vld[0] ? rq0[0].data : '0;
        exp_data[1] = exp_vld[1] ? rq1[0].data : '0;
        for (int p = 0; p < 2; p++) begin
            obs_rdy[p]  = req_ready[p];
            obs_vld[p]  = rsp_valid[p];
            obs_data[p] = rsp_rdata[p];
        end
        @(posedge clk);
        if (rst) begin
            rq0.delete();
            rq1.delete();
            last_g = 1;
        end else begin
            if (exp_vld[0] && rsp_ready[0]) void'(rq0.pop_front());
            if (exp_vld[1] && rsp_ready[1]) void'(rq1.pop_front());
            if (g >= 0) begin
                last_g = g;
                if (req_write[g]) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (req_wstrb[g][b]) mem_model[req_addr[g]][b*8 +: 8] = req_wdata[g][b*8 +: 8];
                    end
                end else begin
                    ent.data  = mem_model[req_addr[g]];
                    ent.avail = cyc + 2;
                    if (g == 0) rq0.push_back(ent);
                    else        rq1.push_back(ent);
                end
            end
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        rst = 1'b1;
        set_req(0, 1'b1, 1'b0, '0, '0, '0);
        set_req(1, 1'b1, 1'b0, '0, '0, '0);
        tick();
        tick();
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (obs_rdy[p] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_req_ready p%0d: observed=%b required=0", p, obs_rdy[p]);
            end
            checks++;
            if (obs_vld[p] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_rsp_valid p%0d: observed=%b required=0", p, obs_vld[p]);
            end
            checks++;
            if (obs_data[p] !== '0) begin
                errors++;
                $display("[TB] FAIL reset_rsp_rdata p%0d: observed=%h required=0", p, obs_data[p]);
            end
        end
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        $display("[TB] test_write_read");
        set_req(0, 1'b1, 1'b1, 10'h005, WORD_A, 16'hFFFF);
        tick();
        checks++;
        if (obs_rdy[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wr_accept: observed=%b required=1", obs_rdy[0]);
        end
        set_req(0, 1'b1, 1'b0, 10'h005, '0, '0);
        tick();
        checks++;
        if (obs_rdy[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rd_accept: observed=%b required=1", obs_rdy[0]);
        end
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        checks++;
        if (obs_vld[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rd_early_valid: observed=%b required=0", obs_vld[0]);
        end
        tick();
        checks++;
        if (obs_vld[0] !== 1'b1 || obs_data[0] !== WORD_A) begin
            errors++;
            $display("[TB] FAIL rd_data: observed=%b/%h required=1/%h", obs_vld[0], obs_data[0], WORD_A);
        end
    endtask

    task automatic test_strobe_merge();
        logic [DATA_W-1:0] want;
        want = {{64{1'b1}}, {64{1'b0}}};
        $display("[TB] test_strobe_merge");
        set_req(0, 1'b1, 1'b1, 10'h010, '1, 16'hFFFF);
        tick();
        set_req(0, 1'b1, 1'b1, 10'h010, '0, 16'h00FF);
        tick();
        set_req(0, 1'b1, 1'b0, 10'h010, '0, '0);
        tick();
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        tick();
        tick();
        checks++;
        if (obs_vld[0] !== 1'b1 || obs_data[0] !== want) begin
            errors++;
            $display("[TB] FAIL strobe_merge: observed=%b/%h required=1/%h", obs_vld[0], obs_data[0], want);
        end
    endtask

    task automatic test_round_robin();
        $display("[TB] test_round_robin");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 10'h005, '0, '0);
        set_req(1, 1'b1, 1'b0, 10'h010, '0, '0);
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (obs_rdy[0] !== ((i % 2) == 0) || obs_rdy[1] !== ((i % 2) == 1)) begin
                errors++;
                $display("[TB] FAIL rr_grant[%0d]: observed=%b%b required=%b%b", i,
                         obs_rdy[0], obs_rdy[1], (i % 2) == 0, (i % 2) == 1);
            end
            for (int p = 0; p < 2; p++) begin
                checks++;
                if (obs_vld[p] !== exp_vld[p] || (exp_vld[p] && obs_data[p] !== exp_data[p])) begin
                    errors++;
                    $display("[TB] FAIL rr_rsp p%0d: observed=%b/%h required=%b/%h", p,
                             obs_vld[p], obs_data[p], exp_vld[p], exp_data[p]);
                end
            end
        end
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_backpressure();
        int                k;
        logic [DATA_W-1:0] got [$];
        $display("[TB] test_backpressure");
        for (int i = 0; i < 4; i++) begin
            set_req(1, 1'b1, 1'b1, ADDR_W'(32'h20 + i), bp_val(i), '1);
            tick();
        end
        k = 0;
        rsp_ready[1] = 1'b0;
        set_req(0, 1'b1, 1'b0, 10'h005, '0, '0);
        for (int i = 0; i < 10; i++) begin
            set_req(1, 1'b1, 1'b0, ADDR_W'(32'h20 + k), '0, '0);
            tick();
            checks++;
            if (obs_rdy[0] !== exp_rdy[0] || obs_rdy[1] !== exp_rdy[1]) begin
                errors++;
                $display("[TB] FAIL bp_grant[%0d]: observed=%b%b required=%b%b", i,
                         obs_rdy[0], obs_rdy[1], exp_rdy[0], exp_rdy[1]);
            end
            if (obs_rdy[1]) k++;
        end
        checks++;
        if (k !== 2) begin
            errors++;
            $display("[TB] FAIL bp_accept_count: observed=%0d required=2", k);
        end
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        rsp_ready[1] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_req(1, k < 4, 1'b0, ADDR_W'(32'h20 + k), '0, '0);
            tick();
            if (obs_rdy[1]) k++;
            if (obs_vld[1]) got.push_back(obs_data[1]);
        end
        checks++;
        if (got.size() !== 4) begin
            errors++;
            $display("[TB] FAIL bp_drain_count: observed=%0d required=4", got.size());
        end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== bp_val(i)) begin
                errors++;
                $display("[TB] FAIL bp_drain_data[%0d]: observed=%h required=%h", i, got[i], bp_val(i));
            end
        end
    endtask

    task automatic test_write_no_credit();
        int acc;
        $display("[TB] test_write_no_credit");
        acc = 0;
        rsp_ready[0] = 1'b0;
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 6; i++) begin
            set_req(0, 1'b1, 1'b0, 10'h005, '0, '0);
            tick();
            if (obs_rdy[0]) acc++;
        end
        checks++;
        if (acc !== 2) begin
            errors++;
            $display("[TB] FAIL nc_read_accepts: observed=%0d required=2", acc);
        end
        for (int i = 0; i < 4; i++) begin
            set_req(0, 1'b1, 1'b1, ADDR_W'(32'h30 + i), {4{32'(i)}}, '1);
            tick();
            checks++;
            if (obs_rdy[0] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL nc_write_accept[%0d]: observed=%b required=1", i, obs_rdy[0]);
            end
        end
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        rsp_ready[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs_vld[0] !== (i < 2) || (i < 2 && obs_data[0] !== WORD_A)) begin
                errors++;
                $display("[TB] FAIL nc_drain[%0d]: observed=%b/%h required=%b/%h", i,
                         obs_vld[0], obs_data[0], i < 2, WORD_A);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        $display("[TB] test_reset_mid_read");
        set_req(0, 1'b1, 1'b0, 10'h005, '0, '0);
        tick();
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs_vld[0] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rmr_stale_valid[%0d]: observed=%b required=0", i, obs_vld[0]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            set_req(0, 1'b1, 1'b0, 10'h005, '0, '0);
            tick();
            checks++;
            if (obs_rdy[0] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL rmr_accept[%0d]: observed=%b required=1", i, obs_rdy[0]);
            end
        end
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs_vld[0] !== (i < 2) || (i < 2 && obs_data[0] !== WORD_A)) begin
                errors++;
                $display("[TB] FAIL rmr_data[%0d]: observed=%b/%h required=%b/%h", i,
                         obs_vld[0], obs_data[0], i < 2, WORD_A);
            end
        end
    endtask

    task automatic test_random();
        $display("[TB] test_random");
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        for (int a = 0; a < 16; a++) begin
            set_req(0, 1'b1, 1'b1, ADDR_W'(a), {$urandom(), $urandom(), $urandom(), $urandom()}, '1);
            tick();
            checks++;
            if (obs_rdy[0] !== 1'b1) begin
                errors++;
                $display("[TB] FAIL rnd_preload[%0d]: observed=%b required=1", a, obs_rdy[0]);
            end
        end
        for (int i = 0; i < 410; i++) begin
            for (int p = 0; p < 2; p++) begin
                set_req(p, (i < 400) && ($urandom_range(0, 3) != 0), $urandom_range(0, 2) == 0,
                        ADDR_W'($urandom_range(0, 15)),
                        {$urandom(), $urandom(), $urandom(), $urandom()}, STRB_W'($urandom()));
                rsp_ready[p] = (i >= 400) || ($urandom_range(0, 3) != 0);
            end
            tick();
            for (int p = 0; p < 2; p++) begin
                checks++;
                if (obs_rdy[p] !== exp_rdy[p]) begin
                    errors++;
                    $display("[TB] FAIL rnd_ready p%0d cyc %0d: observed=%b required=%b", p, cyc, obs_rdy[p], exp_rdy[p]);
                end
                checks++;
                if (obs_vld[p] !== exp_vld[p]) begin
                    errors++;
                    $display("[TB] FAIL rnd_valid p%0d cyc %0d: observed=%b required=%b", p, cyc, obs_vld[p], exp_vld[p]);
                end
                if (exp_vld[p]) begin
                    checks++;
                    if (obs_data[p] !== exp_data[p]) begin
                        errors++;
                        $display("[TB] FAIL rnd_data p%0d cyc %0d: observed=%h required=%h", p, cyc, obs_data[p], exp_data[p]);
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        rsp_ready[0] = 1'b1;
        rsp_ready[1] = 1'b1;
        test_reset();
        test_write_read();
        test_strobe_merge();
        test_round_robin();
        test_backpressure();
        test_write_no_credit();
        test_reset_mid_read();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
